// File: rtl/axi_mgr_stim_engine.sv
// AXI4-Lite manager stimulus engine: queues bench commands and plays them one at a time on AW/W/B/AR/R.
// Optional error statistics (err_cnt, err_sticky) are built when AXI_STIM_ERRCNT_EN is defined.
module axi_mgr_stim_engine #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [4:0]          tx_en,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY,
    output logic                rsp_valid,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic [4:0]          new_data,
    output logic                busy
`ifdef AXI_STIM_ERRCNT_EN
    ,
    output logic [15:0]         err_cnt,
    output logic [1:0]          err_sticky
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t                r_state;
    logic                  r_fifo_wr   [DEPTH];
    logic [ADDR_W-1:0]     r_fifo_addr [DEPTH];
    logic [DATA_W-1:0]     r_fifo_data [DEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_W-1:0]     r_awaddr, r_araddr;
    logic [DATA_W-1:0]     r_wdata, r_rsp_data;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_awvalid, r_wvalid, r_arvalid;
    logic                  r_aw_done, r_w_done;
    logic                  r_rsp_valid, r_rsp_write;
    logic [1:0]            r_rsp_resp;
    logic [4:0]            r_new_data;

    logic w_push, w_pop, w_not_full, w_bready, w_rready;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [1:0] w_rsp_resp;

    // cmd_ready comes from the registered count only, so a full FIFO never accepts in a pop cycle
    assign w_not_full = (r_count != CNT_W'(DEPTH));
    assign w_push     = cmd_valid && w_not_full;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_bready   = (r_state == S_WR_RESP) && tx_en[2];
    assign w_rready   = (r_state == S_RD_DATA) && tx_en[0];
    assign w_aw_hs    = r_awvalid && AWREADY;
    assign w_w_hs     = r_wvalid && WREADY;
    assign w_b_hs     = BVALID && w_bready;
    assign w_ar_hs    = r_arvalid && ARREADY;
    assign w_r_hs     = RVALID && w_rready;
    assign w_rsp_resp = w_b_hs ? BRESP : RRESP;

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_fifo_wr[r_wptr]   <= cmd_write;
            r_fifo_addr[r_wptr] <= cmd_addr;
            r_fifo_data[r_wptr] <= cmd_data;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_resp  <= '0;
            r_new_data  <= '0;
        end else begin
            r_new_data  <= {w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs};
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // VALIDs may rise together with the pop so the channel is live one edge after acceptance
                    if (w_pop) begin
                        if (r_fifo_wr[r_rptr]) begin
                            r_awaddr  <= r_fifo_addr[r_rptr];
                            r_wdata   <= r_fifo_data[r_rptr];
                            r_wstrb   <= '1;
                            r_awvalid <= tx_en[4];
                            r_wvalid  <= tx_en[3];
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR_ADDR_DATA;
                        end else begin
                            r_araddr  <= r_fifo_addr[r_rptr];
                            r_arvalid <= tx_en[1];
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end else if (!r_awvalid && !r_aw_done && tx_en[4]) begin
                        r_awvalid <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end else if (!r_wvalid && !r_w_done && tx_en[3]) begin
                        r_wvalid <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_resp  <= w_rsp_resp;
                        r_state     <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RD_DATA;
                    end else if (!r_arvalid && tx_en[1]) begin
                        r_arvalid <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_data  <= RDATA;
                        r_rsp_resp  <= w_rsp_resp;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_STIM_ERRCNT_EN
    logic        w_rsp_done;
    logic [15:0] r_err_cnt;
    logic [1:0]  r_err_sticky;

    assign w_rsp_done = w_b_hs || w_r_hs;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_err_cnt    <= '0;
            r_err_sticky <= '0;
        end else if (w_rsp_done && (w_rsp_resp != 2'b00)) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            if (r_err_sticky == 2'b00) r_err_sticky <= w_rsp_resp;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;
`endif

    assign cmd_ready = w_not_full;
    assign AWADDR    = r_awaddr;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WVALID    = r_wvalid;
    assign BREADY    = w_bready;
    assign ARADDR    = r_araddr;
    assign ARVALID   = r_arvalid;
    assign RREADY    = w_rready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_data  = r_rsp_data;
    assign rsp_resp  = r_rsp_resp;
    assign new_data  = r_new_data;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);
endmodule
